ldb_shell: RTL and testbench

Load-buffer engine, the read-direction counterpart of the store buffer. Accepts one load micro-instruction, issues interleaved read requests to the SMC memory fabric, collects in-order read responses and writes them into the user-register (UR) file with word masking. Sits between the micro-instruction dispatcher and the SMC read port; exposes the same micro-instruction fields and one-hot state vector as the store path.

---
 rtl/ldb_pkg.sv | 41 ++++
 rtl/ldb_addr_gen.sv | 61 ++++++
 rtl/ldb_shell.sv | 233 +++++++++++++++++++++++
 tb/tb_ldb_shell.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldb_pkg
//  Description : Shared types and helpers for the load-buffer engine:
//                one-hot FSM encodings, burst decode and word-to-byte
//                strobe expansion.
//  Revision    : 1.0 - initial release
// ============================================================================
package ldb_pkg;

    // One-hot state encodings, exported unchanged on o_state
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_LOAD  = 5'b00010,
        ST_ISSUE = 5'b00100,
        ST_DRAIN = 5'b01000,
        ST_DONE  = 5'b10000
    } ldb_state_e;

    // Beat counters must hold 1..256 (32 SMCs x 8 beats)
    localparam int c_CNT_W = 9;

    // Beats per SMC: 00=1, 01=2, 10=4, 11=8
    function automatic logic [3:0] burst_beats(input logic [1:0] brst);
        return 4'd1 << brst;
    endfunction

    // Each 32-bit word enable covers four bytes; an all-zero mask means every word
    function automatic logic [15:0] expand_word_strb(input logic [3:0] word_strb);
        logic [15:0] v;
        v = '0;
        for (int w = 0; w < 4; w++) begin
            if (word_strb[w] || (word_strb == 4'h0)) begin
                v[4*w +: 4] = 4'hF;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldb_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ldb_addr_gen
//  Description : Read-address walker. Beats step by 16 bytes inside an SMC,
//                SMCs step by INTLV_STEP. Advances only on request handshake
//                so the presented address is held while the fabric stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldb_addr_gen
    import ldb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int INTLV_STEP = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [1:0]            i_brst,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_STEP       = ADDR_WIDTH'(INTLV_STEP);
    localparam logic [ADDR_WIDTH-1:0] c_BEAT_BYTES = ADDR_WIDTH'(16);

    logic [2:0]            r_beat;
    logic [ADDR_WIDTH-1:0] r_smc_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            w_last_beat;
    logic                  w_smc_end;

    assign w_last_beat = burst_beats(i_brst) - 4'd1;
    assign w_smc_end   = ({1'b0, r_beat} == w_last_beat);

    // Walk beats within an SMC, then hop to the next SMC base (wraps mod 2^ADDR_WIDTH)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat     <= '0;
            r_smc_addr <= '0;
            r_addr     <= '0;
        end else if (i_clear) begin
            r_beat     <= '0;
            r_smc_addr <= i_base;
            r_addr     <= i_base;
        end else if (i_advance) begin
            if (w_smc_end) begin
                r_beat     <= '0;
                r_smc_addr <= r_smc_addr + c_STEP;
                r_addr     <= r_smc_addr + c_STEP;
            end else begin
                r_beat     <= r_beat + 3'd1;
                r_addr     <= r_addr + c_BEAT_BYTES;
            end
        end
    end

    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/ldb_shell.sv
`default_nettype none
// ============================================================================
//  Module      : ldb_shell
//  Description : Load-buffer engine. Accepts one load micro-instruction,
//                issues interleaved SMC read requests, and writes the
//                in-order responses into the UR file with word masking.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldb_shell
    import ldb_pkg::*;
#(
    parameter int UR_ADDR_WIDTH = 11,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 128,
    parameter int INTLV_STEP    = 128,
    parameter int MAX_OUTSTD    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_micro_inst_u_valid,
    input  logic [5:0]               i_micro_inst_u_smc_strb,
    input  logic [3:0]               i_micro_inst_u_byte_strb,
    input  logic [1:0]               i_micro_inst_u_brst,
    input  logic [ADDR_WIDTH-1:0]    i_micro_inst_u_gr_base_addr,
    input  logic [3:0]               i_micro_inst_u_ur_id,
    input  logic [UR_ADDR_WIDTH-1:0] i_micro_inst_u_ur_addr,
    output logic                     o_micro_inst_d_valid,
    output logic                     o_micro_inst_d_done,
    output logic                     o_rd_req_valid,
    input  logic                     i_rd_req_ready,
    output logic [ADDR_WIDTH-1:0]    o_rd_req_addr,
    input  logic                     i_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    i_rd_rsp_data,
    output logic                     o_ur_wr_en,
    output logic [3:0]               o_ur_wr_id,
    output logic [UR_ADDR_WIDTH-1:0] o_ur_wr_addr,
    output logic [DATA_WIDTH-1:0]    o_ur_wr_data,
    output logic [15:0]              o_ur_wr_strb,
    output logic [4:0]               o_state
);

    localparam int                 c_OUT_W   = $clog2(MAX_OUTSTD) + 1;
    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUTSTD);

    ldb_state_e               r_state;
    ldb_state_e               w_state_nxt;

    // Latched instruction fields
    logic [4:0]               r_smc_last;
    logic [3:0]               r_byte_strb;
    logic [1:0]               r_brst;
    logic [ADDR_WIDTH-1:0]    r_base;
    logic [3:0]               r_ur_id;

    logic [c_CNT_W-1:0]       r_total;
    logic [c_CNT_W-1:0]       r_issued;
    logic [c_CNT_W-1:0]       r_received;
    logic [c_OUT_W-1:0]       r_outstd;
    logic [UR_ADDR_WIDTH-1:0] r_ur_ptr;

    logic                     r_d_valid;
    logic                     r_ur_wr_en;
    logic [3:0]               r_ur_wr_id;
    logic [UR_ADDR_WIDTH-1:0] r_ur_wr_addr;
    logic [DATA_WIDTH-1:0]    r_ur_wr_data;
    logic [15:0]              r_ur_wr_strb;

    logic [c_CNT_W-1:0]       w_smc_cnt;
    logic [c_CNT_W-1:0]       w_total;
    logic                     w_accept;
    logic                     w_load;
    logic                     w_req_valid;
    logic                     w_req_fire;
    logic                     w_rsp_take;
    logic                     w_last_req;
    logic                     w_done;
    logic                     w_unused;

    // SMC index bit 5 and the sub-beat address bits carry no meaning here
    assign w_unused = ^{i_micro_inst_u_smc_strb[5], i_micro_inst_u_gr_base_addr[3:0]};

    assign w_accept   = (r_state == ST_IDLE) && i_micro_inst_u_valid;
    assign w_load     = (r_state == ST_LOAD);
    assign w_smc_cnt  = {4'b0000, r_smc_last} + 9'd1;
    assign w_total    = w_smc_cnt * {5'b00000, burst_beats(r_brst)};
    assign w_last_req = (r_issued == (r_total - 9'd1));
    assign w_req_fire = w_req_valid && i_rd_req_ready;
    // A response with nothing in flight is stale (e.g. after an abort) and is dropped
    assign w_rsp_take = i_rd_rsp_valid && (r_outstd != '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and FSM-derived outputs; valid depends only on registers
    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_micro_inst_u_valid) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_req_valid = (r_issued < r_total) && (r_outstd < c_MAX_OUT);
                if (w_req_valid && i_rd_req_ready && w_last_req) begin
                    w_state_nxt = (r_received == r_total) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_received == r_total) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture instruction fields on accept and echo a one-cycle accept pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smc_last  <= '0;
            r_byte_strb <= '0;
            r_brst      <= '0;
            r_base      <= '0;
            r_ur_id     <= '0;
            r_d_valid   <= 1'b0;
        end else begin
            r_d_valid <= w_accept;
            if (w_accept) begin
                r_smc_last  <= i_micro_inst_u_smc_strb[4:0];
                r_byte_strb <= i_micro_inst_u_byte_strb;
                r_brst      <= i_micro_inst_u_brst;
                r_base      <= {i_micro_inst_u_gr_base_addr[ADDR_WIDTH-1:4], 4'b0000};
                r_ur_id     <= i_micro_inst_u_ur_id;
            end
        end
    end

    // Transfer bookkeeping: total size, issued/received counts and in-flight depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total    <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_outstd   <= '0;
        end else begin
            if (w_load) begin
                r_total    <= w_total;
                r_issued   <= '0;
                r_received <= '0;
            end else begin
                if (w_req_fire) begin
                    r_issued <= r_issued + 9'd1;
                end
                if (w_rsp_take) begin
                    r_received <= r_received + 9'd1;
                end
            end
            unique case ({w_req_fire, w_rsp_take})
                2'b10:   r_outstd <= r_outstd + 1'b1;
                2'b01:   r_outstd <= r_outstd - 1'b1;
                default: r_outstd <= r_outstd;
            endcase
        end
    end

    // Registered UR write port; entry pointer walks from ur_addr with natural wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ur_ptr     <= '0;
            r_ur_wr_en   <= 1'b0;
            r_ur_wr_id   <= '0;
            r_ur_wr_addr <= '0;
            r_ur_wr_data <= '0;
            r_ur_wr_strb <= '0;
        end else begin
            r_ur_wr_en <= w_rsp_take;
            if (w_accept) begin
                r_ur_ptr <= i_micro_inst_u_ur_addr;
            end else if (w_rsp_take) begin
                r_ur_ptr <= r_ur_ptr + 1'b1;
            end
            if (w_rsp_take) begin
                r_ur_wr_id   <= r_ur_id;
                r_ur_wr_addr <= r_ur_ptr;
                r_ur_wr_data <= i_rd_rsp_data;
                r_ur_wr_strb <= expand_word_strb(r_byte_strb);
            end
        end
    end

    ldb_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INTLV_STEP (INTLV_STEP)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_load),
        .i_base    (r_base),
        .i_brst    (r_brst),
        .i_advance (w_req_fire),
        .o_addr    (o_rd_req_addr)
    );

    assign o_micro_inst_d_valid = r_d_valid;
    assign o_micro_inst_d_done  = w_done;
    assign o_rd_req_valid       = w_req_valid;
    assign o_ur_wr_en           = r_ur_wr_en;
    assign o_ur_wr_id           = r_ur_wr_id;
    assign o_ur_wr_addr         = r_ur_wr_addr;
    assign o_ur_wr_data         = r_ur_wr_data;
    assign o_ur_wr_strb         = r_ur_wr_strb;
    assign o_state              = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ldb_shell.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldb_shell
//  Description : Directed bench for ldb_shell: vector table of load
//                instructions against an in-order memory fabric model, plus
//                hand-written outstanding-limit and mid-operation reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ldb_shell;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_micro_inst_u_valid;
    logic [5:0]   i_micro_inst_u_smc_strb;
    logic [3:0]   i_micro_inst_u_byte_strb;
    logic [1:0]   i_micro_inst_u_brst;
    logic [31:0]  i_micro_inst_u_gr_base_addr;
    logic [3:0]   i_micro_inst_u_ur_id;
    logic [10:0]  i_micro_inst_u_ur_addr;
    logic         o_micro_inst_d_valid;
    logic         o_micro_inst_d_done;
    logic         o_rd_req_valid;
    logic         i_rd_req_ready;
    logic [31:0]  o_rd_req_addr;
    logic         i_rd_rsp_valid;
    logic [127:0] i_rd_rsp_data;
    logic         o_ur_wr_en;
    logic [3:0]   o_ur_wr_id;
    logic [10:0]  o_ur_wr_addr;
    logic [127:0] o_ur_wr_data;
    logic [15:0]  o_ur_wr_strb;
    logic [4:0]   o_state;

    ldb_shell dut (
        .clk                         (clk),
        .rst                         (rst),
        .i_micro_inst_u_valid        (i_micro_inst_u_valid),
        .i_micro_inst_u_smc_strb     (i_micro_inst_u_smc_strb),
        .i_micro_inst_u_byte_strb    (i_micro_inst_u_byte_strb),
        .i_micro_inst_u_brst         (i_micro_inst_u_brst),
        .i_micro_inst_u_gr_base_addr (i_micro_inst_u_gr_base_addr),
        .i_micro_inst_u_ur_id        (i_micro_inst_u_ur_id),
        .i_micro_inst_u_ur_addr      (i_micro_inst_u_ur_addr),
        .o_micro_inst_d_valid        (o_micro_inst_d_valid),
        .o_micro_inst_d_done         (o_micro_inst_d_done),
        .o_rd_req_valid              (o_rd_req_valid),
        .i_rd_req_ready              (i_rd_req_ready),
        .o_rd_req_addr               (o_rd_req_addr),
        .i_rd_rsp_valid              (i_rd_rsp_valid),
        .i_rd_rsp_data               (i_rd_rsp_data),
        .o_ur_wr_en                  (o_ur_wr_en),
        .o_ur_wr_id                  (o_ur_wr_id),
        .o_ur_wr_addr                (o_ur_wr_addr),
        .o_ur_wr_data                (o_ur_wr_data),
        .o_ur_wr_strb                (o_ur_wr_strb),
        .o_state                     (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0]  smc;
        logic [3:0]  bs;
        logic [1:0]  brst;
        logic [31:0] base;
        logic [3:0]  id;
        logic [10:0] ur;
        bit          stall;
        int          exp_total;
        logic [15:0] exp_strb;
        logic [31:0] exp_last_addr;
        logic [10:0] exp_last_ur;
    } vec_t;

    vec_t vt[6];
    vec_t va, vb;

    int n_vec = 0;
    int n_bad = 0;

    // Fabric model state
    logic [31:0]  pend[$];
    logic [31:0]  req_log[$];
    int           req_cyc[$];
    bit           ready_en = 1'b1;
    bit           stall = 1'b0;
    int           rsp_credit = -1;

    // UR write monitor state
    logic [10:0]  wr_addr[$];
    logic [127:0] wr_data[$];
    logic [15:0]  wr_strb[$];
    logic [3:0]   wr_id[$];
    int           last_wr_cyc = -10;
    int           n_done = 0;

    function automatic logic [127:0] data_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'h0BAD_F00D};
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // In-order memory fabric: responds no earlier than the cycle after the request
    initial begin
        i_rd_req_ready = 1'b0;
        i_rd_rsp_valid = 1'b0;
        i_rd_rsp_data  = '0;
        forever begin
            @(posedge clk); #2;
            i_rd_rsp_valid = 1'b0;
            if (pend.size() > 0 && rsp_credit != 0 && (!stall || $urandom_range(0, 1) == 1)) begin
                i_rd_rsp_valid = 1'b1;
                i_rd_rsp_data  = data_of(pend.pop_front());
                if (rsp_credit > 0) rsp_credit--;
            end
            i_rd_req_ready = ready_en && (!stall || $urandom_range(0, 2) != 0);
            if (o_rd_req_valid && i_rd_req_ready) begin
                pend.push_back(o_rd_req_addr);
                req_log.push_back(o_rd_req_addr);
                req_cyc.push_back(cyc);
            end
        end
    end

    // UR write and completion monitor
    initial begin
        forever begin
            @(posedge clk); #3;
            if (o_ur_wr_en) begin
                wr_addr.push_back(o_ur_wr_addr);
                wr_data.push_back(o_ur_wr_data);
                wr_strb.push_back(o_ur_wr_strb);
                wr_id.push_back(o_ur_wr_id);
                last_wr_cyc = cyc;
            end
            if (o_micro_inst_d_done) n_done++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issue one instruction; returns at the cycle of the first request (T+2)
    task automatic start(input vec_t v);
        pend.delete(); req_log.delete(); req_cyc.delete();
        wr_addr.delete(); wr_data.delete(); wr_strb.delete(); wr_id.delete();
        n_done = 0;
        stall  = v.stall;
        i_micro_inst_u_smc_strb     = v.smc;
        i_micro_inst_u_byte_strb    = v.bs;
        i_micro_inst_u_brst         = v.brst;
        i_micro_inst_u_gr_base_addr = v.base;
        i_micro_inst_u_ur_id        = v.id;
        i_micro_inst_u_ur_addr      = v.ur;
        i_micro_inst_u_valid        = 1'b1;
        @(posedge clk); #1;
        i_micro_inst_u_valid = 1'b0;
        chk("accept_pulse", o_micro_inst_d_valid, 1'b1);
        chk("state_load", o_state, 5'b00010);
        @(posedge clk); #1;
        chk("first_req_valid", o_rd_req_valid, 1'b1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            if (o_micro_inst_d_done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("done_seen", seen, 1'b1);
        if (seen) begin
            chk("state_done", o_state, 5'b10000);
            chk("done_after_last_write", last_wr_cyc, cyc - 1);
            @(posedge clk); #1;
            chk("idle_after_done", o_state, 5'b00001);
            chk("done_single_pulse", n_done, 1);
        end
    endtask

    task automatic check_logs(input vec_t v, input bit chk_tput);
        int          nb;
        logic [31:0] abase, e;
        nb    = 1 << v.brst;
        abase = {v.base[31:4], 4'h0};
        chk("req_count", req_log.size(), v.exp_total);
        chk("wr_count", wr_addr.size(), v.exp_total);
        for (int k = 0; k < req_log.size(); k++) begin
            e = abase + 32'(k / nb) * 32'd128 + 32'(k % nb) * 32'd16;
            chk("req_addr", req_log[k], e);
        end
        for (int j = 0; j < wr_addr.size(); j++) begin
            chk("ur_addr", wr_addr[j], 11'(v.ur + 11'(j)));
            chk("ur_strb", wr_strb[j], v.exp_strb);
            chk("ur_id", wr_id[j], v.id);
            if (j < req_log.size()) chk("ur_data", wr_data[j], data_of(req_log[j]));
        end
        if (req_log.size() > 0) chk("last_req_addr", req_log[$], v.exp_last_addr);
        if (wr_addr.size() > 0) chk("last_ur_addr", wr_addr[$], v.exp_last_ur);
        if (chk_tput && req_cyc.size() > 0) chk("issue_throughput", req_cyc[$] - req_cyc[0], v.exp_total - 1);
    endtask

    task automatic run_vec(input vec_t v);
        rsp_credit = -1;
        ready_en   = 1'b1;
        start(v);
        wait_done();
        check_logs(v, !v.stall);
    endtask

    initial begin
        vt[0] = '{smc:6'd0,  bs:4'h0, brst:2'd0, base:32'h0000_1000, id:4'd3,  ur:11'h000, stall:1'b0,
                  exp_total:1,   exp_strb:16'hFFFF, exp_last_addr:32'h0000_1000, exp_last_ur:11'h000};
        vt[1] = '{smc:6'd1,  bs:4'h0, brst:2'd3, base:32'h0000_5000, id:4'd5,  ur:11'h040, stall:1'b0,
                  exp_total:16,  exp_strb:16'hFFFF, exp_last_addr:32'h0000_50F0, exp_last_ur:11'h04F};
        vt[2] = '{smc:6'd0,  bs:4'hB, brst:2'd0, base:32'h0000_2008, id:4'd1,  ur:11'h100, stall:1'b0,
                  exp_total:1,   exp_strb:16'hF0FF, exp_last_addr:32'h0000_2000, exp_last_ur:11'h100};
        vt[3] = '{smc:6'd0,  bs:4'h0, brst:2'd1, base:32'hFFFF_FFF0, id:4'd7,  ur:11'h7FF, stall:1'b0,
                  exp_total:2,   exp_strb:16'hFFFF, exp_last_addr:32'h0000_0000, exp_last_ur:11'h000};
        vt[4] = '{smc:6'd2,  bs:4'h1, brst:2'd2, base:32'h0000_3000, id:4'd15, ur:11'h200, stall:1'b1,
                  exp_total:12,  exp_strb:16'h000F, exp_last_addr:32'h0000_3130, exp_last_ur:11'h20B};
        vt[5] = '{smc:6'h3F, bs:4'h6, brst:2'd3, base:32'h0001_0000, id:4'd9,  ur:11'h7F0, stall:1'b0,
                  exp_total:256, exp_strb:16'h0FF0, exp_last_addr:32'h0001_0FF0, exp_last_ur:11'h0EF};
        va    = '{smc:6'd1,  bs:4'h0, brst:2'd3, base:32'h0000_8000, id:4'd2,  ur:11'h000, stall:1'b0,
                  exp_total:16,  exp_strb:16'hFFFF, exp_last_addr:32'h0000_80F0, exp_last_ur:11'h00F};
        vb    = '{smc:6'd2,  bs:4'h0, brst:2'd0, base:32'h0000_4000, id:4'd4,  ur:11'h010, stall:1'b0,
                  exp_total:3,   exp_strb:16'hFFFF, exp_last_addr:32'h0000_4100, exp_last_ur:11'h012};

        i_micro_inst_u_valid        = 1'b0;
        i_micro_inst_u_smc_strb     = '0;
        i_micro_inst_u_byte_strb    = '0;
        i_micro_inst_u_brst         = '0;
        i_micro_inst_u_gr_base_addr = '0;
        i_micro_inst_u_ur_id        = '0;
        i_micro_inst_u_ur_addr      = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", o_state, 5'b00001);
        chk("rst_d_valid", o_micro_inst_d_valid, 1'b0);
        chk("rst_d_done", o_micro_inst_d_done, 1'b0);
        chk("rst_req_valid", o_rd_req_valid, 1'b0);
        chk("rst_req_addr", o_rd_req_addr, 32'h0);
        chk("rst_ur_wr", {o_ur_wr_en, o_ur_wr_id, o_ur_wr_addr, o_ur_wr_strb}, '0);
        chk("rst_ur_data", o_ur_wr_data, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Outstanding limit: withhold responses until eight requests are in flight
        rsp_credit = 0;
        ready_en   = 1'b1;
        start(va);
        for (int k = 0; k < 40 && req_log.size() < 8; k++) begin @(posedge clk); #1; end
        chk("outstd_reqs", req_log.size(), 8);
        chk("outstd_valid_low", o_rd_req_valid, 1'b0);
        ready_en = 1'b0;
        i_micro_inst_u_valid = 1'b1;      // must be ignored outside IDLE
        @(posedge clk); #1;
        i_micro_inst_u_valid = 1'b0;
        chk("busy_no_accept", o_micro_inst_d_valid, 1'b0);
        chk("outstd_still_low", o_rd_req_valid, 1'b0);
        @(posedge clk); #1;
        ready_en   = 1'b1;
        rsp_credit = 1;
        chk("outstd_before_rsp", o_rd_req_valid, 1'b0);
        @(posedge clk); #1;
        chk("outstd_resume", o_rd_req_valid, 1'b1);
        chk("outstd_first_wr", o_ur_wr_en, 1'b1);
        chk("outstd_first_wr_addr", o_ur_wr_addr, 11'h000);
        rsp_credit = -1;
        wait_done();
        check_logs(va, 1'b0);

        // Reset in DRAIN with three responses pending
        rsp_credit = 0;
        start(vb);
        for (int k = 0; k < 40 && o_state != 5'b01000; k++) begin @(posedge clk); #1; end
        chk("rst_seq_drain", o_state, 5'b01000);
        chk("rst_seq_reqs", req_log.size(), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", o_state, 5'b00001);
        chk("abort_req_valid", o_rd_req_valid, 1'b0);
        rsp_credit = -1;
        repeat (6) begin @(posedge clk); #1; end
        chk("abort_no_writes", wr_addr.size(), 0);
        chk("abort_idle", o_state, 5'b00001);
        run_vec(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
